// File: rtl/hs_unit_shreg_arb_if.sv
// Request/data/grant bundle between requesters and the shared-register arbiter.
// The lock vector exists only when HS_SHREG_ARB_LOCK_EN is defined.
interface hs_unit_shreg_arb_if #(
    parameter int  NUM_REQ   = 4,
    parameter type DATA_TYPE = logic [7:0]
);
    localparam int OW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
`ifdef HS_SHREG_ARB_LOCK_EN
    logic [NUM_REQ-1:0] lock;
`endif
    DATA_TYPE           din [NUM_REQ];
    logic               clr;
    logic [NUM_REQ-1:0] gnt;
    DATA_TYPE           dout;
    logic               dout_vld;
    logic [OW-1:0]      owner;
    logic               locked;

`ifdef HS_SHREG_ARB_LOCK_EN
    modport master (output req, lock, din, clr, input gnt, dout, dout_vld, owner, locked);
    modport slave  (input req, lock, din, clr, output gnt, dout, dout_vld, owner, locked);
`else
    modport master (output req, din, clr, input gnt, dout, dout_vld, owner, locked);
    modport slave  (input req, din, clr, output gnt, dout, dout_vld, owner, locked);
`endif
endinterface

// File: rtl/hs_unit_shreg_arb.sv
// Round-robin arbiter/write sequencer in front of one shared data register.
// HS_SHREG_ARB_LOCK_EN enables the lock port, LOCKED state and MAX_LOCK bound.
//
// state     | meaning
// ST_ARB    | round-robin search from ptr each cycle
// ST_LOCKED | owner may keep writing until lock drops or MAX_LOCK grants reached
module hs_unit_shreg_arb #(
    parameter int       NUM_REQ     = 4,
    parameter type      DATA_TYPE   = logic [7:0],
    parameter DATA_TYPE RESET_VALUE = '0,
    parameter int       MAX_LOCK    = 4
) (
    input  logic               clk,
    input  logic               sclr,
    hs_unit_shreg_arb_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      owner_q;
    logic [PW-1:0]      win;
    logic [PW-1:0]      ptr_nxt;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] gnt_c;
    logic               found;
    logic               hold;
    int                 idx;
    DATA_TYPE           dout_q;
    logic               vld_q;

`ifdef HS_SHREG_ARB_LOCK_EN
    typedef enum logic {ST_ARB, ST_LOCKED} state_t;

    localparam logic [7:0] LOCK_LIM = 8'(MAX_LOCK);

    state_t             state_q;
    state_t             state_d;
    logic [7:0]         cnt_q;
    logic [7:0]         cnt_d;
    logic [NUM_REQ-1:0] own_oh;

    assign own_oh = NUM_REQ'(1) << owner_q;
`endif

    always_comb begin
        cand  = bus.req;
        hold  = 1'b0;
        found = 1'b0;
        win   = ptr_q;
        idx   = 0;
`ifdef HS_SHREG_ARB_LOCK_EN
        hold = (state_q == ST_LOCKED) && bus.req[owner_q] && bus.lock[owner_q]
               && (cnt_q < LOCK_LIM);
        // Forced release: the exhausted owner yields whenever anyone else asks.
        if ((state_q == ST_LOCKED) && (cnt_q == LOCK_LIM) && ((bus.req & ~own_oh) != '0))
            cand[owner_q] = 1'b0;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ)
                idx = idx - NUM_REQ;
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
        if (hold) begin
            found = 1'b1;
            win   = owner_q;
        end
    end

    always_comb begin
        gnt_c = '0;
        if (!sclr && !bus.clr && found)
            gnt_c[win] = 1'b1;
    end

    always_comb begin
        if (hold)
            ptr_nxt = ptr_q;
        else if (win == PW'(NUM_REQ - 1))
            ptr_nxt = '0;
        else
            ptr_nxt = win + PW'(1);
    end

`ifdef HS_SHREG_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q <= ST_ARB;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.clr) begin
            state_d = ST_ARB;
            cnt_d   = '0;
        end else if (hold) begin
            state_d = ST_LOCKED;
            cnt_d   = cnt_q + 8'd1;
        end else if (found && bus.lock[win]) begin
            state_d = ST_LOCKED;
            cnt_d   = 8'd1;
        end else begin
            state_d = ST_ARB;
            cnt_d   = '0;
        end
    end

    assign bus.locked = (state_q == ST_LOCKED);
`else
    assign bus.locked = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (sclr) begin
            dout_q  <= RESET_VALUE;
            vld_q   <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else if (bus.clr) begin
            dout_q <= RESET_VALUE;
            vld_q  <= 1'b0;
        end else if (found) begin
            dout_q  <= bus.din[win];
            owner_q <= win;
            ptr_q   <= ptr_nxt;
            vld_q   <= 1'b1;
        end else begin
            vld_q <= 1'b0;
        end
    end

    assign bus.gnt      = gnt_c;
    assign bus.dout     = dout_q;
    assign bus.dout_vld = vld_q;
    assign bus.owner    = owner_q;

    a_gnt_onehot: assert property (@(posedge clk) $onehot0(bus.gnt));

endmodule

// File: tb/tb_hs_unit_shreg_arb.sv
// Scoreboard bench for hs_unit_shreg_arb: directed scenarios then random traffic,
// checked against a queue-based reference model (lock behaviour follows HS_SHREG_ARB_LOCK_EN).
module tb_hs_unit_shreg_arb;
    localparam int         N    = 4;
    localparam int         MAXL = 4;
    localparam logic [7:0] RV   = 8'h00;
`ifdef HS_SHREG_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    typedef struct {
        logic       vld;
        logic [7:0] dout;
        int         owner;
        logic       locked;
    } exp_t;

    logic       clk = 1'b0;
    logic       sclr;
    logic [7:0] din_tb [N];
    exp_t       sbq [$];
    int         errors = 0;
    int         checks = 0;

    logic [7:0] m_dout;
    int         m_owner;
    int         m_ptr;
    int         m_run;
    bit         m_locked;

    always #5 clk = ~clk;

    hs_unit_shreg_arb_if #(.NUM_REQ(N), .DATA_TYPE(logic [7:0])) bus ();

    hs_unit_shreg_arb #(
        .NUM_REQ(N), .DATA_TYPE(logic [7:0]), .RESET_VALUE(RV), .MAX_LOCK(MAXL)
    ) dut (
        .clk (clk),
        .sclr(sclr),
        .bus (bus)
    );

    // Drive one cycle of inputs, predict the grant and post-edge outputs.
    task automatic cycle(input bit s, input bit c, input logic [N-1:0] r, input logic [N-1:0] lk);
        int         g;
        int         cnd;
        bit         excl;
        logic [N-1:0] eg;
        exp_t       e;
        sclr    = s;
        bus.clr = c;
        bus.req = r;
`ifdef HS_SHREG_ARB_LOCK_EN
        bus.lock = lk;
`endif
        for (int i = 0; i < N; i++) bus.din[i] = din_tb[i];
        #1;
        g = -1;
        if (s) begin
            m_dout = RV; m_owner = 0; m_ptr = 0; m_locked = 0; m_run = 0;
        end else if (c) begin
            m_dout = RV; m_locked = 0; m_run = 0;
        end else begin
            if (LOCK_EN && m_locked && r[m_owner] && lk[m_owner] && m_run < MAXL) begin
                g = m_owner;
                m_run = m_run + 1;
            end else begin
                excl = LOCK_EN && m_locked && (m_run >= MAXL) && ((r & ~(N'(1) << m_owner)) != '0);
                for (int k = 0; k < N; k++) begin
                    cnd = (m_ptr + k) % N;
                    if (g < 0 && r[cnd] && !(excl && cnd == m_owner)) g = cnd;
                end
                if (g >= 0) begin
                    m_ptr = (g + 1) % N;
                    if (LOCK_EN && lk[g]) begin m_locked = 1; m_run = 1; end
                    else begin m_locked = 0; m_run = 0; end
                end else begin
                    m_locked = 0; m_run = 0;
                end
            end
            if (g >= 0) begin
                m_dout  = din_tb[g];
                m_owner = g;
            end
        end
        eg = (g >= 0) ? (N'(1) << g) : '0;
        checks++;
        if (bus.gnt !== eg) begin
            errors++;
            $display("FAIL gnt t=%0t got=%b exp=%b", $time, bus.gnt, eg);
        end
        e.vld = (g >= 0); e.dout = m_dout; e.owner = m_owner; e.locked = m_locked;
        sbq.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: pop one expectation per edge and compare the registered outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if (bus.dout_vld !== e.vld) begin
                    errors++;
                    $display("FAIL dout_vld t=%0t got=%b exp=%b", $time, bus.dout_vld, e.vld);
                end
                checks++;
                if (bus.dout !== e.dout) begin
                    errors++;
                    $display("FAIL dout t=%0t got=%h exp=%h", $time, bus.dout, e.dout);
                end
                checks++;
                if ($isunknown(bus.owner) || int'(bus.owner) != e.owner) begin
                    errors++;
                    $display("FAIL owner t=%0t got=%0d exp=%0d", $time, bus.owner, e.owner);
                end
                checks++;
                if (bus.locked !== e.locked) begin
                    errors++;
                    $display("FAIL locked t=%0t got=%b exp=%b", $time, bus.locked, e.locked);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) din_tb[i] = 8'h10 + 8'(i);
        m_dout = RV; m_owner = 0; m_ptr = 0; m_run = 0; m_locked = 0;

        // Reset with all requests asserted
        repeat (2) cycle(1'b1, 1'b0, 4'b1111, 4'b0000);
        // Round-robin sweep
        repeat (8) cycle(1'b0, 1'b0, 4'b1111, 4'b0000);
        // Move ptr to 3, then wrap to source 0, then idle
        cycle(1'b0, 1'b0, 4'b0100, 4'b0000);
        cycle(1'b0, 1'b0, 4'b0001, 4'b0000);
        repeat (2) cycle(1'b0, 1'b0, 4'b0000, 4'b0000);
        // Lock bound: source 0 holds lock against source 1
        repeat (14) cycle(1'b0, 1'b0, 4'b0011, 4'b0001);
        // Clear mid-lock with A5 in the register
        din_tb[0] = 8'hA5;
        repeat (2) cycle(1'b0, 1'b0, 4'b0001, 4'b0001);
        cycle(1'b0, 1'b1, 4'b0011, 4'b0001);
        cycle(1'b0, 1'b0, 4'b0000, 4'b0000);
        // Reset mid-lock
        repeat (2) cycle(1'b0, 1'b0, 4'b0100, 4'b0100);
        cycle(1'b1, 1'b0, 4'b0100, 4'b0100);
        // Random traffic
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) din_tb[i] = 8'($urandom);
            cycle(($urandom_range(31) == 0), ($urandom_range(15) == 0),
                  N'($urandom), N'($urandom | $urandom));
        end
        cycle(1'b0, 1'b0, 4'b0000, 4'b0000);

        @(posedge clk);
        #2;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
